xif_offload_issuer: RTL
=======================

Name: xif_offload_issuer

Overview:
- Core-side (initiator) end of the eXtension interface that rvfpm answers as coprocessor.
- Takes offloadable instructions from the core decode stage and drives the issue handshake.
- Sequences commit/kill per issued ID and tracks outstanding IDs in a scoreboard.
- Accepts results and forwards them to the core writeback port.
- Memory request/result channels are out of scope for this block.

Parameters:
X_ID_WIDTH, 4, width of transaction ID; scoreboard has 2**X_ID_WIDTH entries
XLEN, 32, integer register/operand width
MAX_OUTSTANDING, 4, max accepted-but-unretired IDs (1..2**X_ID_WIDTH)

Ports:
ck  in  1  clock
rst  in  1  synchronous active-low reset
instr_valid  in  1  core offers instruction
instr_ready  out  1  issuer can take instruction
instr  in  32  instruction word
rs0, rs1  in  XLEN each  source operands (always valid)
issue_valid  out  1  issue request valid
issue_ready  in  1  coprocessor takes request
issue_req  out  x_issue_req_t  instr, id, rs[0..1], rs_valid=2'b11
issue_resp  in  x_issue_resp_t  accept, writeback (sampled with issue handshake)
spec_resolved  in  1  core resolved speculation of the pending instruction
spec_kill  in  1  with spec_resolved: kill instead of commit
commit_valid  out  1  commit strobe
commit  out  x_commit_t  id, commit_kill
result_valid  in  1  coprocessor result valid
result_ready  out  1  equals wb_ready
result  in  x_result_t  id, data, rd, we
wb_valid  out  1  writeback to integer RF
wb_ready  in  1  core can accept writeback
wb_rd  out  5  destination register
wb_data  out  XLEN  writeback data
rejected  out  1  one-cycle pulse: issue not accepted
protocol_err  out  1  one-cycle pulse: result for an ID not awaiting one
outstanding  out  X_ID_WIDTH+1  count of scoreboard entries valid

Behaviour:
- Reset (rst==0 at posedge ck): FSM=IDLE, next_id=0, scoreboard cleared, all outputs 0.
- Reset mid-transaction drops everything with no commit emitted; rst has priority over all other events.
- FSM IDLE:
  - instr_ready=1 iff outstanding<MAX_OUTSTANDING and scoreboard[next_id].valid==0.
  - On instr_valid&&instr_ready: latch instr/rs0/rs1, id=next_id, go ISSUE.
- FSM ISSUE:
  - issue_valid=1; issue_req held stable until issue_ready.
  - On issue_ready: next_id<=next_id+1 (wraps mod 2**X_ID_WIDTH); go COMMIT.
  - If accept: scoreboard[id] <= {valid=1, wb=writeback, committed=0}.
  - If not accept: pulse rejected the following cycle; no scoreboard entry is made, but a commit is still emitted for the ID.
- FSM COMMIT:
  - Wait for spec_resolved; spec_resolved may already be high on entry.
  - On spec_resolved: commit_valid=1 for exactly one cycle, with commit.id=id and commit.commit_kill=spec_kill; go IDLE.
  - Accepted, killed or wb==0: free the entry in the same cycle as the commit strobe.
  - Otherwise set committed=1.
- Issue latency: issue_valid rises the cycle after the instr handshake. Minimum 3 cycles from instr handshake to the next instr_ready.
- Result path (independent of the FSM):
  - result_ready=wb_ready.
  - On result_valid&&result_ready with entry valid&&committed&&wb: wb_valid=result.we, wb_rd=result.rd, wb_data=result.data (registered, 1-cycle latency); free the entry.
  - Any other case pulses protocol_err and is dropped.
- Simultaneous free (result) and alloc (issue) on different IDs are both applied.
- outstanding updates by +1, -1 or 0 accordingly; it never exceeds MAX_OUTSTANDING.

Decomposition:
- Struct types x_issue_req_t, x_issue_resp_t, x_commit_t, x_result_t stay in the shared in_xif package.
- Add to in_xif: FSM state enum issuer_state_e, scoreboard entry struct sb_entry_t.
- One sub-module: xif_id_scoreboard.
  - Entry array with alloc/commit/free ports.
  - Outputs: outstanding count and per-ID lookup.

Test Plan:
- Single accepted op (instr 0x00B50553, writeback=1), spec_resolved at once, result id 0 data 0x3F800000 rd 10 -> commit id0 kill0; wb_valid with rd 10, data 0x3F800000; outstanding back to 0.
- Rejected op (accept=0) -> rejected pulse; commit id0 still emitted; next instruction gets id1; outstanding stays 0.
- Killed op (spec_kill=1) -> commit_kill=1; entry freed; a later result with that id -> protocol_err pulse, wb_valid stays 0.
- Four accepted ops with results withheld -> instr_ready low at outstanding=4; first result -> instr_ready high again, fifth op issued.
- 17 sequential ops -> ids wrap 15->0; alloc blocked while id0 still valid.
- Reset asserted in ISSUE state holding issue_valid -> all outputs 0 next cycle, no commit, next instruction gets id0.

Source files
------------

// File: rtl/in_xif.sv
// in_xif: shared eXtension interface types plus issuer FSM and scoreboard types
package in_xif;
    localparam int X_ID_WIDTH = 4;
    localparam int XLEN = 32;
    localparam int X_NUM_IDS = 2 ** X_ID_WIDTH;
    typedef logic [X_ID_WIDTH-1:0] x_id_t;
    typedef logic [X_ID_WIDTH:0] x_cnt_t;
    typedef struct packed {
        logic [31:0] instr;
        x_id_t id;
        logic [1:0][XLEN-1:0] rs;
        logic [1:0] rs_valid;
    } x_issue_req_t;
    typedef struct packed {
        logic accept;
        logic writeback;
    } x_issue_resp_t;
    typedef struct packed {
        x_id_t id;
        logic commit_kill;
    } x_commit_t;
    typedef struct packed {
        x_id_t id;
        logic [XLEN-1:0] data;
        logic [4:0] rd;
        logic we;
    } x_result_t;
    typedef enum logic [1:0] { IDLE, ISSUE, COMMIT } issuer_state_e;
    typedef struct packed {
        logic valid;
        logic wb;
        logic committed;
    } sb_entry_t;
endpackage

// File: rtl/xif_offload_issuer_if.sv
// xif_offload_issuer_if: issue/commit/result channels between issuer (master) and coprocessor (slave)
interface xif_offload_issuer_if;
    logic issue_valid;
    logic issue_ready;
    in_xif::x_issue_req_t issue_req;
    in_xif::x_issue_resp_t issue_resp;
    logic commit_valid;
    in_xif::x_commit_t commit;
    logic result_valid;
    logic result_ready;
    in_xif::x_result_t result;
    modport master (
        output issue_valid, issue_req, commit_valid, commit, result_ready,
        input issue_ready, issue_resp, result_valid, result
    );
    modport slave (
        input issue_valid, issue_req, commit_valid, commit, result_ready,
        output issue_ready, issue_resp, result_valid, result
    );
endinterface

// File: rtl/xif_id_scoreboard.sv
// xif_id_scoreboard: per-ID entry array with alloc/commit/free and an outstanding count
// ports: ck/rst (sync active-low); alloc_*, cmt_*, free_* update ports;
//        busy_id->busy and lk_id->lk lookups; outstanding = number of valid entries
module xif_id_scoreboard
    import in_xif::*;
(
    input  logic ck,
    input  logic rst,
    input  logic alloc_en,
    input  x_id_t alloc_id,
    input  logic alloc_wb,
    input  logic cmt_en,
    input  x_id_t cmt_id,
    input  logic cmt_free,
    input  logic free_en,
    input  x_id_t free_id,
    input  x_id_t busy_id,
    output logic busy,
    input  x_id_t lk_id,
    output sb_entry_t lk,
    output x_cnt_t outstanding
);
    sb_entry_t sb [X_NUM_IDS];
    assign busy = sb[busy_id].valid;
    assign lk = sb[lk_id];
    always_ff @(posedge ck) begin
        if (!rst) begin
            for (int i = 0; i < X_NUM_IDS; i++) sb[i] <= '0;
            outstanding <= '0;
        end else begin
            if (alloc_en) sb[alloc_id] <= sb_entry_t'{valid: 1'b1, wb: alloc_wb, committed: 1'b0};
            if (cmt_en) sb[cmt_id] <= sb_entry_t'{valid: !cmt_free, wb: sb[cmt_id].wb && !cmt_free, committed: !cmt_free};
            if (free_en) sb[free_id] <= '0;
            // commit-free and result-free hit different IDs, so both may land in one cycle
            outstanding <= outstanding + x_cnt_t'(alloc_en) - x_cnt_t'(cmt_en && cmt_free) - x_cnt_t'(free_en);
        end
    end
endmodule

// File: rtl/xif_offload_issuer.sv
// xif_offload_issuer: core-side eXtension interface initiator (issue, commit/kill, result to writeback)
// ports: ck/rst (sync active-low); instr_valid/instr_ready/instr/rs0/rs1 from decode;
//        xif master channels; spec_resolved/spec_kill; wb_* writeback; rejected/protocol_err pulses; outstanding
module xif_offload_issuer
    import in_xif::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic ck,
    input  logic rst,
    input  logic instr_valid,
    output logic instr_ready,
    input  logic [31:0] instr,
    input  logic [XLEN-1:0] rs0,
    input  logic [XLEN-1:0] rs1,
    xif_offload_issuer_if.master xif,
    input  logic spec_resolved,
    input  logic spec_kill,
    output logic wb_valid,
    input  logic wb_ready,
    output logic [4:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic rejected,
    output logic protocol_err,
    output x_cnt_t outstanding
);
    localparam x_cnt_t MAX_CNT = x_cnt_t'(MAX_OUTSTANDING);
    issuer_state_e state;
    x_id_t next_id;
    logic cur_acc;
    logic cur_wb;
    logic next_busy;
    sb_entry_t res_entry;
    logic commit_fire;
    logic res_fire;
    logic res_ok;
    assign commit_fire = state == COMMIT && spec_resolved;
    assign res_fire = xif.result_valid && wb_ready;
    assign res_ok = res_entry.valid && res_entry.committed && res_entry.wb;
    assign xif.result_ready = wb_ready;
    // gated by rst so nothing is offered to the core while reset is held
    assign instr_ready = rst && state == IDLE && outstanding < MAX_CNT && !next_busy;

    xif_id_scoreboard u_sb (
        .ck(ck),
        .rst(rst),
        .alloc_en(state == ISSUE && xif.issue_ready && xif.issue_resp.accept),
        .alloc_id(xif.issue_req.id),
        .alloc_wb(xif.issue_resp.writeback),
        .cmt_en(commit_fire && cur_acc),
        .cmt_id(xif.issue_req.id),
        .cmt_free(spec_kill || !cur_wb),
        .free_en(res_fire && res_ok),
        .free_id(xif.result.id),
        .busy_id(next_id),
        .busy(next_busy),
        .lk_id(xif.result.id),
        .lk(res_entry),
        .outstanding(outstanding)
    );

    always_ff @(posedge ck) begin
        if (!rst) begin
            state <= IDLE;
            next_id <= '0;
            cur_acc <= 1'b0;
            cur_wb <= 1'b0;
            rejected <= 1'b0;
            xif.issue_valid <= 1'b0;
            xif.issue_req <= '0;
            xif.commit_valid <= 1'b0;
            xif.commit <= '0;
        end else begin
            xif.commit_valid <= 1'b0;
            rejected <= 1'b0;
            case (state)
                IDLE: if (instr_valid && instr_ready) begin
                    xif.issue_valid <= 1'b1;
                    xif.issue_req <= {instr, next_id, rs1, rs0, 2'b11};
                    state <= ISSUE;
                end
                ISSUE: if (xif.issue_ready) begin
                    xif.issue_valid <= 1'b0;
                    next_id <= next_id + 1'b1;
                    cur_acc <= xif.issue_resp.accept;
                    cur_wb <= xif.issue_resp.writeback;
                    rejected <= !xif.issue_resp.accept;
                    state <= COMMIT;
                end
                COMMIT: if (spec_resolved) begin
                    xif.commit_valid <= 1'b1;
                    xif.commit <= {xif.issue_req.id, spec_kill};
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_rd <= '0;
            wb_data <= '0;
            protocol_err <= 1'b0;
        end else begin
            wb_valid <= res_fire && res_ok && xif.result.we;
            protocol_err <= res_fire && !res_ok;
            if (res_fire && res_ok) begin
                wb_rd <= xif.result.rd;
                wb_data <= xif.result.data;
            end
        end
    end
endmodule
